// File: rtl/rv32i_regfile_mp.sv
// Multi-port integer register file with write-to-read bypass, a per-register
// busy scoreboard and a registered write-port conflict flag; x0 reads as zero.
module rv32i_regfile_mp #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NRD    = 2,
   parameter int NWR    = 2,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NRD*AW-1:0]     rd_addr,
   output logic [NRD*XLEN-1:0]   rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic [NWR-1:0]        wr_en,
   input  logic [NWR*AW-1:0]     wr_addr,
   input  logic [NWR*XLEN-1:0]   wr_data,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_rd,
   output logic [NREGS-1:0]      busy_vec,
   output logic                  wr_conflict
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] busy;
   logic [NREGS-1:0] busy_nxt;
   logic [NREGS-1:0] reg_we;
   logic [XLEN-1:0]  reg_wdata [NREGS];
   logic             wr_conflict_nxt;

   // Per-register write decode; later ports overwrite earlier ones, so the highest index wins.
   always_comb begin
      reg_we = '0;
      for (int r = 0; r < NREGS; r++) reg_wdata[r] = '0;
      for (int w = 0; w < NWR; w++) begin
         if (wr_en[w] && wr_addr[w*AW +: AW] != '0) begin
            reg_we[wr_addr[w*AW +: AW]]    = 1'b1;
            reg_wdata[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
         end
      end
   end

   always_comb begin
      wr_conflict_nxt = 1'b0;
      for (int i = 0; i < NWR; i++) begin
         for (int j = i + 1; j < NWR; j++) begin
            if (wr_en[i] && wr_en[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]
                && wr_addr[i*AW +: AW] != '0)
               wr_conflict_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (reg_we[r]) regs[r] <= reg_wdata[r];
         end
      end
   end

   // Issue is applied after the writeback clear so a newer writer keeps ownership.
   always_comb begin
      busy_nxt = busy & ~reg_we;
      if (iss_en && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy        <= '0;
         wr_conflict <= 1'b0;
      end else begin
         busy        <= busy_nxt;
         wr_conflict <= wr_conflict_nxt;
      end
   end

   assign busy_vec = busy;

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   addr;
      logic [XLEN-1:0] data;
      logic            bsy;

      assign addr = rd_addr[p*AW +: AW];

      always_comb begin
         data = regs[addr];
         bsy  = busy[addr];
         if (BYPASS != 0 && reg_we[addr]) begin
            data = reg_wdata[addr];
            bsy  = 1'b0;
         end
         if (addr == '0) begin
            data = '0;
            bsy  = 1'b0;
         end
      end

      assign rd_data[p*XLEN +: XLEN] = data;
      assign rd_busy[p]              = bsy;
   end

endmodule

// File: tb/tb_rv32i_regfile_mp.sv
// Bench for rv32i_regfile_mp: bypassing and non-bypassing instances driven in
// lockstep and compared each cycle against a queued reference-model prediction.
module tb_rv32i_regfile_mp;
   localparam int XLEN  = 32;
   localparam int NREGS = 16;
   localparam int NRD   = 3;
   localparam int NWR   = 2;
   localparam int AW    = 4;

   logic                clk = 1'b0;
   logic                reset;
   logic [NRD*AW-1:0]   rd_addr;
   logic [NWR-1:0]      wr_en;
   logic [NWR*AW-1:0]   wr_addr;
   logic [NWR*XLEN-1:0] wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_rd;

   logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
   logic [NRD-1:0]      rd_busy_b, rd_busy_n;
   logic [NREGS-1:0]    busy_vec_b, busy_vec_n;
   logic                conf_b, conf_n;

   always #5 clk = ~clk;

   rv32i_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
      .busy_vec(busy_vec_b), .wr_conflict(conf_b));

   rv32i_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .iss_en(iss_en), .iss_rd(iss_rd),
      .busy_vec(busy_vec_n), .wr_conflict(conf_n));

   logic [XLEN-1:0]  m_regs [NREGS];
   logic [NREGS-1:0] m_busy;
   logic             m_conf;

   typedef struct {
      logic [NRD*XLEN-1:0] data_b;
      logic [NRD*XLEN-1:0] data_n;
      logic [NRD-1:0]      busy_b;
      logic [NRD-1:0]      busy_n;
      logic [NREGS-1:0]    bvec;
      logic                conf;
   } exp_t;

   exp_t  sb[$];
   string tq[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_read(input bit byp, output logic [NRD*XLEN-1:0] d,
                                      output logic [NRD-1:0] b);
      for (int p = 0; p < NRD; p++) begin
         logic [AW-1:0]   a;
         logic [XLEN-1:0] v;
         logic            bz;
         a  = rd_addr[p*AW +: AW];
         v  = m_regs[a];
         bz = m_busy[a];
         if (byp) begin
            for (int w = 0; w < NWR; w++) begin
               if (wr_en[w] && wr_addr[w*AW +: AW] == a) begin
                  v  = wr_data[w*XLEN +: XLEN];
                  bz = 1'b0;
               end
            end
         end
         if (a == 0) begin
            v  = '0;
            bz = 1'b0;
         end
         d[p*XLEN +: XLEN] = v;
         b[p]              = bz;
      end
   endfunction

   task automatic model_update();
      if (reset) begin
         for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
         m_busy = '0;
         m_conf = 1'b0;
      end else begin
         logic c;
         c = 1'b0;
         for (int i = 0; i < NWR; i++)
            for (int j = i + 1; j < NWR; j++)
               if (wr_en[i] && wr_en[j] && wr_addr[i*AW +: AW] == wr_addr[j*AW +: AW]
                   && wr_addr[i*AW +: AW] != 0)
                  c = 1'b1;
         for (int w = 0; w < NWR; w++) begin
            if (wr_en[w] && wr_addr[w*AW +: AW] != 0) begin
               m_regs[wr_addr[w*AW +: AW]] = wr_data[w*XLEN +: XLEN];
               m_busy[wr_addr[w*AW +: AW]] = 1'b0;
            end
         end
         if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
         m_conf = c;
      end
   endtask

   task automatic idle();
      rd_addr = '0;
      wr_en   = '0;
      wr_addr = '0;
      wr_data = '0;
      iss_en  = 1'b0;
      iss_rd  = '0;
   endtask

   task automatic rd(input int p, input logic [AW-1:0] a);
      rd_addr[p*AW +: AW] = a;
   endtask

   task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wr_en[p]                = 1'b1;
      wr_addr[p*AW +: AW]     = a;
      wr_data[p*XLEN +: XLEN] = d;
   endtask

   task automatic iss(input logic [AW-1:0] a);
      iss_en = 1'b1;
      iss_rd = a;
   endtask

   function automatic logic [AW-1:0] pick();
      if ($urandom_range(0, 2) == 0) return AW'($urandom_range(0, 3));
      return AW'($urandom_range(0, NREGS - 1));
   endfunction

   // Predict at the drive point, check mid-cycle, then advance the model on the edge.
   task automatic step(input string tag);
      exp_t  e;
      exp_t  g;
      string t;
      model_read(1'b1, e.data_b, e.busy_b);
      model_read(1'b0, e.data_n, e.busy_n);
      e.bvec = m_busy;
      e.conf = m_conf;
      sb.push_back(e);
      tq.push_back(tag);
      #2;
      g = sb.pop_front();
      t = tq.pop_front();
      chk({t, ":rd_data_byp"}, 128'(rd_data_b), 128'(g.data_b));
      chk({t, ":rd_data_nob"}, 128'(rd_data_n), 128'(g.data_n));
      chk({t, ":rd_busy_byp"}, 128'(rd_busy_b), 128'(g.busy_b));
      chk({t, ":rd_busy_nob"}, 128'(rd_busy_n), 128'(g.busy_n));
      chk({t, ":busy_vec_byp"}, 128'(busy_vec_b), 128'(g.bvec));
      chk({t, ":busy_vec_nob"}, 128'(busy_vec_n), 128'(g.bvec));
      chk({t, ":wr_conflict_byp"}, 128'(conf_b), 128'(g.conf));
      chk({t, ":wr_conflict_nob"}, 128'(conf_n), 128'(g.conf));
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   initial begin
      for (int r = 0; r < NREGS; r++) m_regs[r] = '0;
      m_busy = '0;
      m_conf = 1'b0;
      idle();
      reset = 1'b1;
      repeat (2) begin
         @(posedge clk);
         model_update();
      end
      @(negedge clk);
      rd(0, 5); rd(1, 3); rd(2, 9);
      step("reset_state");
      #1 chk("rst_busy_vec", 128'(busy_vec_b), 128'(0));
      chk("rst_conflict", 128'(conf_b), 128'(0));

      // Write x5, then reset while also writing x6 and issuing x6.
      reset = 1'b0;
      idle(); wr(0, 5, 32'hDEADBEEF); iss(4); step("t1_wr");
      idle(); rd(0, 5); rd(1, 4); step("t1_rd");
      reset = 1'b1;
      idle(); rd(0, 5); wr(1, 6, 32'h66); iss(6); step("t1_rst");
      reset = 1'b0;
      idle(); rd(0, 5); rd(1, 6); rd(2, 4);
      #1 chk("t1_x5_zero", 128'(rd_data_b[31:0]), 128'(0));
      chk("t1_bvec_zero", 128'(busy_vec_n), 128'(0));
      step("t1_after");

      // Two ports writing x3 in one cycle.
      idle(); wr(0, 3, 32'h11); wr(1, 3, 32'h22); rd(0, 3); step("t2_wr");
      idle(); rd(0, 3);
      #1 chk("t2_conf_pulse", 128'(conf_b), 128'(1));
      chk("t2_x3", 128'(rd_data_n[31:0]), 128'(32'h22));
      step("t2_next");
      idle(); rd(0, 3); step("t2_clear");
      idle(); wr(0, 0, 32'h1); wr(1, 0, 32'h2); step("t2_x0_pair");
      idle(); wr(0, 1, 32'h1); wr(1, 2, 32'h2); step("t2_distinct");
      idle(); rd(0, 1); rd(1, 2); step("t2_distinct_rd");

      // Same-cycle bypass versus stored value.
      idle(); wr(1, 7, 32'h1234); step("t3_seed");
      idle(); wr(0, 7, 32'hCAFE); rd(0, 7); rd(2, 7);
      #1 chk("t3_byp", 128'(rd_data_b[31:0]), 128'(32'hCAFE));
      chk("t3_nobyp", 128'(rd_data_n[31:0]), 128'(32'h1234));
      step("t3_same");
      idle(); rd(0, 7); step("t3_after");

      // x0 is never written and never busy.
      idle(); wr(1, 0, 32'hFFFFFFFF); iss(0); rd(0, 0); rd(1, 0); rd(2, 0); step("t4_x0");
      idle(); rd(0, 0); step("t4_x0_after");

      // Scoreboard on x9.
      idle(); iss(9); rd(1, 9); step("t5_iss");
      idle(); rd(1, 9); step("t5_busy");
      idle(); iss(9); wr(0, 9, 32'h5); rd(1, 9); step("t5_iss_wr");
      idle(); rd(1, 9);
      #1 chk("t5_still_busy", 128'(busy_vec_b[9]), 128'(1));
      step("t5_hold");
      idle(); wr(1, 9, 32'h7); rd(1, 9); step("t5_wr_only");
      idle(); rd(1, 9); step("t5_free");
      idle(); iss(9); step("t5_iss2");
      idle(); iss(9); rd(0, 9); step("t5_reissue");

      for (int n = 0; n < 10000; n++) begin
         idle();
         reset = ($urandom_range(0, 199) == 0);
         for (int p = 0; p < NRD; p++) rd(p, pick());
         for (int w = 0; w < NWR; w++)
            if ($urandom_range(0, 2) != 0) wr(w, pick(), $urandom());
         if ($urandom_range(0, 1) != 0) iss(pick());
         step("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
